// File: rtl/rat_cu_pkg.sv
// rat_cu_pkg: shared definitions for the RAT control unit.
//   - state_t   : control FSM states
//   - OP_*      : five-bit opcode groups (instruction bits [17:13])
//   - ALU_*     : ALU operation selects
//   - ctrl_t    : bundle of every control output, produced by the decoder
//   - alu_of_idx: maps the 3-bit "eight-op" index shared by the register and
//                 immediate ALU forms to an ALU select
package rat_cu_pkg;

    // ST_INIT is encoded as zero so a zero-initialising power-up lands in it.
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_INTR  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_ADDC = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_SUBC = 4'd3;
    localparam logic [3:0] ALU_CMP  = 4'd4;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_EXOR = 4'd7;
    localparam logic [3:0] ALU_TEST = 4'd8;
    localparam logic [3:0] ALU_MOV  = 4'd14;

    localparam logic [4:0] OP_REG_LOGIC  = 5'b00000;
    localparam logic [4:0] OP_REG_ARITH  = 5'b00001;
    localparam logic [4:0] OP_REG_CMPMOV = 5'b00010;
    localparam logic [4:0] OP_BR_Z       = 5'b00100;
    localparam logic [4:0] OP_BR_C       = 5'b00101;
    localparam logic [4:0] OP_STACK      = 5'b01001;
    localparam logic [4:0] OP_FLAG_RET   = 5'b01100;
    localparam logic [4:0] OP_INT_RETI   = 5'b01101;
    localparam logic [4:0] OP_CMP_IMM    = 5'b11000;
    localparam logic [4:0] OP_IN         = 5'b11001;
    localparam logic [4:0] OP_OUT        = 5'b11010;
    localparam logic [4:0] OP_MOV_IMM    = 5'b11011;
    localparam logic [1:0] OP_ALU_IMM_PFX = 2'b10;

    localparam logic [1:0] PC_SRC_IMM  = 2'd0;
    localparam logic [1:0] PC_SRC_SCR  = 2'd1;
    localparam logic [1:0] PC_SRC_INTR = 2'd2;
    localparam logic [1:0] RF_SRC_SCR  = 2'd1;
    localparam logic [1:0] RF_SRC_IN   = 2'd3;
    localparam logic [1:0] SCR_AT_SP    = 2'd2;
    localparam logic [1:0] SCR_AT_SP_M1 = 2'd3;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_inc;
        logic [1:0] pc_mux_sel;
        logic       alu_opy_sel;
        logic [3:0] alu_sel;
        logic       rf_wr;
        logic [1:0] rf_wr_sel;
        logic       sp_incr;
        logic       sp_decr;
        logic       scr_we;
        logic [1:0] scr_addr_sel;
        logic       scr_data_sel;
        logic       flg_c_set;
        logic       flg_c_clr;
        logic       flg_c_ld;
        logic       flg_z_ld;
        logic       flg_ld_sel;
        logic       flg_shad_ld;
        logic       i_set;
        logic       i_clr;
        logic       rst;
        logic       io_strb;
    } ctrl_t;

    // Index 0-3 are the logic ops, 4-7 the arithmetic ops.
    function automatic logic [3:0] alu_of_idx(input logic [2:0] idx);
        logic [3:0] sel;
        case (idx)
            3'd0:    sel = ALU_AND;
            3'd1:    sel = ALU_OR;
            3'd2:    sel = ALU_EXOR;
            3'd3:    sel = ALU_TEST;
            3'd4:    sel = ALU_ADD;
            3'd5:    sel = ALU_ADDC;
            3'd6:    sel = ALU_SUB;
            3'd7:    sel = ALU_SUBC;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rat_ctrl_unit_if.sv
// rat_ctrl_unit_if: instruction/flag inputs and control outputs of the RAT
// control unit.
//   master: instruction source side (drives opcode fields, flags, INT_CU)
//   slave : control unit side (drives every datapath control)
interface rat_ctrl_unit_if;
    logic [4:0] OPCODE_HI_5;
    logic [1:0] OPCODE_LOW_2;
    logic       INT_CU;
    logic       C_FLAG;
    logic       Z_FLAG;
    logic       PC_LD;
    logic       PC_INC;
    logic [1:0] PC_MUX_SEL;
    logic       ALU_OPY_SEL;
    logic [3:0] ALU_SEL;
    logic       RF_WR;
    logic [1:0] RF_WR_SEL;
    logic       SP_INCR;
    logic       SP_DECR;
    logic       SCR_WE;
    logic [1:0] SCR_ADDR_SEL;
    logic       SCR_DATA_SEL;
    logic       FLG_C_SET;
    logic       FLG_C_CLR;
    logic       FLG_C_LD;
    logic       FLG_Z_LD;
    logic       FLG_LD_SEL;
    logic       FLG_SHAD_LD;
    logic       I_SET;
    logic       I_CLR;
    logic       RST;
    logic       IO_STRB;

    modport master (
        output OPCODE_HI_5, OPCODE_LOW_2, INT_CU, C_FLAG, Z_FLAG,
        input  PC_LD, PC_INC, PC_MUX_SEL, ALU_OPY_SEL, ALU_SEL, RF_WR, RF_WR_SEL,
               SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, FLG_C_SET,
               FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD, I_SET,
               I_CLR, RST, IO_STRB
    );

    modport slave (
        input  OPCODE_HI_5, OPCODE_LOW_2, INT_CU, C_FLAG, Z_FLAG,
        output PC_LD, PC_INC, PC_MUX_SEL, ALU_OPY_SEL, ALU_SEL, RF_WR, RF_WR_SEL,
               SP_INCR, SP_DECR, SCR_WE, SCR_ADDR_SEL, SCR_DATA_SEL, FLG_C_SET,
               FLG_C_CLR, FLG_C_LD, FLG_Z_LD, FLG_LD_SEL, FLG_SHAD_LD, I_SET,
               I_CLR, RST, IO_STRB
    );
endinterface

// File: rtl/rat_cu_decode.sv
// rat_cu_decode: purely combinational instruction decoder for the EXEC cycle.
//   opcode_hi : instruction bits [17:13]
//   opcode_lo : instruction bits [1:0]
//   c_flag    : current carry flag (conditional branches)
//   z_flag    : current zero flag (conditional branches)
//   ctrl      : control outputs for this instruction; all zero for an
//               undefined opcode, which therefore executes as a NOP
module rat_cu_decode
    import rat_cu_pkg::*;
(
    input  logic [4:0] opcode_hi,
    input  logic [1:0] opcode_lo,
    input  logic       c_flag,
    input  logic       z_flag,
    output ctrl_t      ctrl
);

    // Opcode decode; every field not named for an instruction stays zero.
    always_comb begin
        ctrl = '0;
        case (opcode_hi)
            OP_REG_LOGIC, OP_REG_ARITH: begin
                // bit 13 picks logic vs arithmetic, LOW picks the op in the group
                ctrl.alu_sel  = alu_of_idx({opcode_hi[0], opcode_lo});
                ctrl.rf_wr    = (ctrl.alu_sel != ALU_TEST);
                ctrl.flg_c_ld = 1'b1;
                ctrl.flg_z_ld = 1'b1;
            end
            OP_REG_CMPMOV: begin
                case (opcode_lo)
                    2'b00: begin
                        ctrl.alu_sel  = ALU_CMP;
                        ctrl.flg_c_ld = 1'b1;
                        ctrl.flg_z_ld = 1'b1;
                    end
                    2'b01: begin
                        ctrl.alu_sel = ALU_MOV;
                        ctrl.rf_wr   = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            OP_BR_Z: begin
                case (opcode_lo)
                    2'b00: ctrl.pc_ld = 1'b1;
                    2'b01: begin
                        // CALL: push return PC at SP-1, then jump
                        ctrl.pc_ld        = 1'b1;
                        ctrl.sp_decr      = 1'b1;
                        ctrl.scr_we       = 1'b1;
                        ctrl.scr_addr_sel = SCR_AT_SP_M1;
                        ctrl.scr_data_sel = 1'b1;
                    end
                    2'b10:   ctrl.pc_ld = z_flag;
                    2'b11:   ctrl.pc_ld = ~z_flag;
                    default: ctrl = '0;
                endcase
            end
            OP_BR_C: begin
                case (opcode_lo)
                    2'b00:   ctrl.pc_ld = c_flag;
                    2'b01:   ctrl.pc_ld = ~c_flag;
                    default: ctrl = '0;
                endcase
            end
            OP_STACK: begin
                case (opcode_lo)
                    2'b01: begin
                        ctrl.scr_we       = 1'b1;
                        ctrl.scr_addr_sel = SCR_AT_SP_M1;
                        ctrl.sp_decr      = 1'b1;
                    end
                    2'b10: begin
                        ctrl.scr_addr_sel = SCR_AT_SP;
                        ctrl.rf_wr        = 1'b1;
                        ctrl.rf_wr_sel    = RF_SRC_SCR;
                        ctrl.sp_incr      = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            OP_FLAG_RET: begin
                case (opcode_lo)
                    2'b00: ctrl.flg_c_clr = 1'b1;
                    2'b01: ctrl.flg_c_set = 1'b1;
                    2'b10: begin
                        ctrl.pc_ld        = 1'b1;
                        ctrl.pc_mux_sel   = PC_SRC_SCR;
                        ctrl.scr_addr_sel = SCR_AT_SP;
                        ctrl.sp_incr      = 1'b1;
                    end
                    default: ctrl = '0;
                endcase
            end
            OP_INT_RETI: begin
                case (opcode_lo)
                    2'b00: ctrl.i_set = 1'b1;
                    2'b01: ctrl.i_clr = 1'b1;
                    2'b10, 2'b11: begin
                        // RETID/RETIE: return and restore flags from the shadow
                        ctrl.pc_ld        = 1'b1;
                        ctrl.pc_mux_sel   = PC_SRC_SCR;
                        ctrl.scr_addr_sel = SCR_AT_SP;
                        ctrl.sp_incr      = 1'b1;
                        ctrl.flg_ld_sel   = 1'b1;
                        ctrl.flg_c_ld     = 1'b1;
                        ctrl.flg_z_ld     = 1'b1;
                        ctrl.i_set        = opcode_lo[0];
                        ctrl.i_clr        = ~opcode_lo[0];
                    end
                    default: ctrl = '0;
                endcase
            end
            OP_CMP_IMM: begin
                ctrl.alu_sel     = ALU_CMP;
                ctrl.alu_opy_sel = 1'b1;
                ctrl.flg_c_ld    = 1'b1;
                ctrl.flg_z_ld    = 1'b1;
            end
            OP_IN: begin
                ctrl.rf_wr     = 1'b1;
                ctrl.rf_wr_sel = RF_SRC_IN;
            end
            OP_OUT: ctrl.io_strb = 1'b1;
            OP_MOV_IMM: begin
                ctrl.alu_sel     = ALU_MOV;
                ctrl.alu_opy_sel = 1'b1;
                ctrl.rf_wr       = 1'b1;
            end
            default: begin
                // 10xxx: immediate forms of the eight ALU ops, bits [15:13] select
                if (opcode_hi[4:3] == OP_ALU_IMM_PFX) begin
                    ctrl.alu_sel     = alu_of_idx(opcode_hi[2:0]);
                    ctrl.alu_opy_sel = 1'b1;
                    ctrl.rf_wr       = (ctrl.alu_sel != ALU_TEST);
                    ctrl.flg_c_ld    = 1'b1;
                    ctrl.flg_z_ld    = 1'b1;
                end else begin
                    ctrl = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/rat_ctrl_unit.sv
// rat_ctrl_unit: RAT CPU control unit (FSM + decoder).
//   INT_EN   : 1 honours INT_CU at the end of EXEC, 0 ignores it
//   WAIT_CYC : 0-3 extra wait cycles after every fetch (slow program memory)
//   CLK      : clock, rising edge
//   RESET    : synchronous active-high reset to ST_INIT
//   bus      : opcode/flag/interrupt inputs and all datapath controls
// Controls are combinational from the current state and the inputs.
module rat_ctrl_unit
    import rat_cu_pkg::*;
#(
    parameter bit          INT_EN   = 1'b1,
    parameter int unsigned WAIT_CYC = 32'd0
) (
    input  logic          CLK,
    input  logic          RESET,
    rat_ctrl_unit_if.slave bus
);

    // Counter value on the last wait cycle; unused when WAIT_CYC is 0.
    localparam logic [1:0] WAIT_LAST = (WAIT_CYC > 32'd0) ? 2'(WAIT_CYC - 32'd1) : 2'd0;

    state_t     state_r;
    state_t     state_s;
    logic [1:0] wait_cnt_r;
    logic [1:0] wait_cnt_s;
    ctrl_t      dec_ctrl_s;
    ctrl_t      ctrl_s;

    rat_cu_decode u_decode (
        .opcode_hi (bus.OPCODE_HI_5),
        .opcode_lo (bus.OPCODE_LOW_2),
        .c_flag    (bus.C_FLAG),
        .z_flag    (bus.Z_FLAG),
        .ctrl      (dec_ctrl_s)
    );

    // State register and wait counter.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r    <= ST_INIT;
            wait_cnt_r <= 2'd0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            ST_INIT: state_s = ST_FETCH;
            ST_FETCH: begin
                wait_cnt_s = 2'd0;
                if (WAIT_CYC > 32'd0) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_EXEC;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_s = ST_EXEC;
                end else begin
                    wait_cnt_s = wait_cnt_r + 2'd1;
                end
            end
            ST_EXEC: begin
                // interrupt is only sampled here, at an instruction boundary
                if (INT_EN && bus.INT_CU) begin
                    state_s = ST_INTR;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_INTR: state_s = ST_FETCH;
            default: state_s = ST_INIT;
        endcase
    end

    // Output selection: decoder only drives the bus during EXEC.
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            ST_INIT:  ctrl_s.rst    = 1'b1;
            ST_FETCH: ctrl_s.pc_inc = 1'b1;
            ST_WAIT:  ctrl_s        = '0;
            ST_EXEC:  ctrl_s        = dec_ctrl_s;
            ST_INTR: begin
                // push PC, vector to ISR, snapshot flags, mask further interrupts
                ctrl_s.pc_ld        = 1'b1;
                ctrl_s.pc_mux_sel   = PC_SRC_INTR;
                ctrl_s.sp_decr      = 1'b1;
                ctrl_s.scr_we       = 1'b1;
                ctrl_s.scr_addr_sel = SCR_AT_SP_M1;
                ctrl_s.scr_data_sel = 1'b1;
                ctrl_s.flg_shad_ld  = 1'b1;
                ctrl_s.i_clr        = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    assign bus.PC_LD        = ctrl_s.pc_ld;
    assign bus.PC_INC       = ctrl_s.pc_inc;
    assign bus.PC_MUX_SEL   = ctrl_s.pc_mux_sel;
    assign bus.ALU_OPY_SEL  = ctrl_s.alu_opy_sel;
    assign bus.ALU_SEL      = ctrl_s.alu_sel;
    assign bus.RF_WR        = ctrl_s.rf_wr;
    assign bus.RF_WR_SEL    = ctrl_s.rf_wr_sel;
    assign bus.SP_INCR      = ctrl_s.sp_incr;
    assign bus.SP_DECR      = ctrl_s.sp_decr;
    assign bus.SCR_WE       = ctrl_s.scr_we;
    assign bus.SCR_ADDR_SEL = ctrl_s.scr_addr_sel;
    assign bus.SCR_DATA_SEL = ctrl_s.scr_data_sel;
    assign bus.FLG_C_SET    = ctrl_s.flg_c_set;
    assign bus.FLG_C_CLR    = ctrl_s.flg_c_clr;
    assign bus.FLG_C_LD     = ctrl_s.flg_c_ld;
    assign bus.FLG_Z_LD     = ctrl_s.flg_z_ld;
    assign bus.FLG_LD_SEL   = ctrl_s.flg_ld_sel;
    assign bus.FLG_SHAD_LD  = ctrl_s.flg_shad_ld;
    assign bus.I_SET        = ctrl_s.i_set;
    assign bus.I_CLR        = ctrl_s.i_clr;
    assign bus.RST          = ctrl_s.rst;
    assign bus.IO_STRB      = ctrl_s.io_strb;

endmodule

// File: doc/rat_ctrl_unit.md
RAT_CTRL_UNIT -- requirements
Module: rat_ctrl_unit

Interface
REQ-001 Parameter INT_EN, default 1: 1 enables the interrupt cycle; 0 ignores INT_CU.
REQ-002 Parameter WAIT_CYC, default 0, range 0-3: extra wait cycles after every fetch for slow program memory.
REQ-003 CLK  in  1  clock; all state changes on rising edge.
REQ-004 RESET  in  1  reset, synchronous, active-high.
REQ-005 OPCODE_HI_5  in  5  instruction bits [17:13].
REQ-006 OPCODE_LOW_2  in  2  instruction bits [1:0].
REQ-007 INT_CU  in  1  gated interrupt request.
REQ-008 C_FLAG, Z_FLAG  in  1 each  current carry and zero flags.
REQ-009 PC_LD, PC_INC  out  1 each  PC load, PC increment.
REQ-010 PC_MUX_SEL  out  2  PC source: 0 immediate, 1 scratch data, 2 interrupt vector.
REQ-011 ALU_OPY_SEL  out  1  ALU operand Y: 0 register, 1 immediate.
REQ-012 ALU_SEL  out  4  ALU op: ADD 0, ADDC 1, SUB 2, SUBC 3, CMP 4, AND 5, OR 6, EXOR 7, TEST 8, MOV 14.
REQ-013 RF_WR  out  1  register file write; RF_WR_SEL  out  2  source: 0 ALU, 1 scratch, 3 IN_PORT.
REQ-014 SP_INCR, SP_DECR  out  1 each  stack pointer step.
REQ-015 SCR_WE  out  1  scratch write; SCR_ADDR_SEL  out  2  address: 2 SP, 3 SP-1.
REQ-016 SCR_DATA_SEL  out  1  scratch data: 0 register, 1 PC.
REQ-017 FLG_C_SET, FLG_C_CLR, FLG_C_LD, FLG_Z_LD  out  1 each  flag controls.
REQ-018 FLG_LD_SEL  out  1  flag source: 0 ALU, 1 shadow; FLG_SHAD_LD  out  1  save flags to shadow.
REQ-019 I_SET, I_CLR  out  1 each  interrupt-enable set/clear.
REQ-020 RST  out  1  datapath reset; IO_STRB  out  1  output-port strobe.

Function
REQ-021 States: ST_INIT, ST_FETCH, ST_WAIT, ST_EXEC, ST_INTR; every output is 0 unless stated.
REQ-022 ST_INIT: RST=1 -> ST_FETCH.
REQ-023 ST_FETCH: PC_INC=1 -> ST_WAIT if WAIT_CYC>0, else ST_EXEC.
REQ-024 ST_WAIT: counter loaded 0 on entry; after WAIT_CYC cycles -> ST_EXEC. Exactly 2+WAIT_CYC cycles per instruction.
REQ-025 ST_EXEC: decode as REQ-026..REQ-031. Next state is ST_INTR if INT_EN=1 and INT_CU=1 in that cycle, else ST_FETCH. INT_CU is ignored in all other states.
REQ-026 ALU ops: HI 00000 gives AND/OR/EXOR/TEST by LOW; 00001 gives ADD/ADDC/SUB/SUBC; 00010_00 is CMP; 00010_01 is MOV, all register form. HI 10000-10111 gives the same eight ops, 11000 gives CMP, 11011 gives MOV, all with ALU_OPY_SEL=1. RF_WR=1 except TEST/CMP; FLG_C_LD=FLG_Z_LD=1 except MOV.
REQ-027 IN 11001: RF_WR=1, RF_WR_SEL=3. OUT 11010: IO_STRB=1 for one cycle.
REQ-028 Branches, PC_MUX_SEL=0: BRN 00100_00 unconditional; BREQ 00100_10 if Z=1; BRNE 00100_11 if Z=0; BRCS 00101_00 if C=1; BRCC 00101_01 if C=0. PC_LD=1 only when the condition holds.
REQ-029 CALL 00100_01: PC_LD, SP_DECR, SCR_WE, SCR_ADDR_SEL=3, SCR_DATA_SEL=1. PUSH 01001_01: SCR_WE, SCR_ADDR_SEL=3, SP_DECR. POP 01001_10: SCR_ADDR_SEL=2, RF_WR, RF_WR_SEL=1, SP_INCR.
REQ-030 RET 01100_10: PC_LD, PC_MUX_SEL=1, SCR_ADDR_SEL=2, SP_INCR. RETID 01101_10 / RETIE 01101_11: as RET, plus FLG_LD_SEL, FLG_C_LD, FLG_Z_LD, and I_CLR / I_SET respectively.
REQ-031 Flag and interrupt control: CLC 01100_00 sets FLG_C_CLR; SEC 01100_01 sets FLG_C_SET; SEI 01101_00 sets I_SET; CLI 01101_01 sets I_CLR.
REQ-032 Undefined opcode: all outputs 0, RST stays 0, normal next state (NOP).
REQ-033 ST_INTR: PC_LD, PC_MUX_SEL=2, SP_DECR, SCR_WE, SCR_ADDR_SEL=3, SCR_DATA_SEL=1, FLG_SHAD_LD, I_CLR -> ST_FETCH.
REQ-034 Outputs are combinational from the present state and inputs; no output is registered.

Reset
REQ-035 RESET=1 at any edge, including mid-ST_WAIT or ST_INTR: state becomes ST_INIT and the wait counter becomes 0; RST=1 in the following cycle.
REQ-036 Power-up state is ST_INIT.

Structure
REQ-037 Package rat_cu_pkg holds the state enum, opcode constants and ALU_SEL constants.
REQ-038 The combinational decoder is the sub-module rat_cu_decode; rat_ctrl_unit holds the state register, wait counter and state-based output overrides.

Verification
REQ-039 RESET pulse -> RST=1 for one cycle, then PC_INC=1, then the EXEC cycle; with WAIT_CYC=2 the instruction period is 4 cycles.
REQ-040 HI=10100 (ADD imm) -> ALU_SEL=0, ALU_OPY_SEL=1, RF_WR=1, FLG_C_LD=FLG_Z_LD=1.
REQ-041 BREQ with Z=0 -> PC_LD=0; with Z=1 -> PC_LD=1, PC_MUX_SEL=0.
REQ-042 INT_CU=1 during EXEC of OUT -> IO_STRB=1, then an INTR cycle with PC_MUX_SEL=2, FLG_SHAD_LD=1, I_CLR=1; INT_EN=0 -> no INTR cycle.
REQ-043 RETIE -> PC_MUX_SEL=1, SP_INCR=1, FLG_LD_SEL=1, I_SET=1; RESET during ST_WAIT -> ST_INIT on the next edge.
